// File: rtl/carry_tree_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : carry_tree_pkg
//  Description : Shared types and constants for the carry-tree adder sweeper.
//  Revision    : 1.0 - initial release
// ============================================================================
package carry_tree_pkg;

    // Exhaustive sweep over {cin, b, a} for a 4-bit adder
    localparam int NUM_VEC    = 512;
    localparam int IDX_W      = 9;
    localparam int NUM_ADDERS = 3;

    // Adder slots; also the bit positions of ff_mask
    localparam int FF_KSA = 0;
    localparam int FF_BKA = 1;
    localparam int FF_SKA = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/carry_tree_sweeper_if.sv
`default_nettype none
// ============================================================================
//  Module      : carry_tree_sweeper_if
//  Description : Control, operand, result and status bundle of the sweeper.
//                slave = sweeper side, master = controller/adder-bank side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface carry_tree_sweeper_if
    import carry_tree_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 10
);
    logic                  start;
    logic                  abort;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  cin;
    logic [WIDTH-1:0]      sum_ksa;
    logic [WIDTH-1:0]      sum_bka;
    logic [WIDTH-1:0]      sum_ska;
    logic                  cout_ksa;
    logic                  cout_bka;
    logic                  cout_ska;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_W-1:0]      err_ksa;
    logic [ERR_W-1:0]      err_bka;
    logic [ERR_W-1:0]      err_ska;
    logic                  ff_valid;
    logic [IDX_W-1:0]      ff_vec;
    logic [NUM_ADDERS-1:0] ff_mask;

    modport master (
        output start, abort,
        output sum_ksa, sum_bka, sum_ska, cout_ksa, cout_bka, cout_ska,
        input  a, b, cin, busy, done, pass,
        input  err_ksa, err_bka, err_ska, ff_valid, ff_vec, ff_mask
    );

    modport slave (
        input  start, abort,
        input  sum_ksa, sum_bka, sum_ska, cout_ksa, cout_bka, cout_ska,
        output a, b, cin, busy, done, pass,
        output err_ksa, err_bka, err_ska, ff_valid, ff_vec, ff_mask
    );

endinterface
`default_nettype wire

// File: rtl/carry_tree_sweeper_golden.sv
`default_nettype none
// ============================================================================
//  Module      : carry_tree_golden
//  Description : Combinational reference {cout,sum} = a + b + cin, computed
//                one bit wider than the operands so nothing is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_tree_golden #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH:0]   result
);

    // Zero-extend all terms so the carry-out lands in result[WIDTH]
    assign result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/carry_tree_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : carry_tree_sweeper
//  Description : Drives all 512 {cin,b,a} vectors into three carry-tree
//                adders, checks each result against a golden sum, and keeps
//                per-adder error counts plus the first failing vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_tree_sweeper
    import carry_tree_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    carry_tree_sweeper_if.slave bus
);

    // The vector index layout {cin,b,a} only fits a 4-bit bank
    generate
        if (WIDTH != 4) begin : g_width_check
            $error("carry_tree_sweeper: WIDTH must be 4");
        end
    endgenerate

    state_e                state_q, state_d;
    // vec_q doubles as the operand register: it reads 0 outside RUN
    logic [IDX_W-1:0]      vec_q, vec_d;
    logic [ERR_W-1:0]      err_q [NUM_ADDERS];
    logic [ERR_W-1:0]      err_d [NUM_ADDERS];
    logic                  ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0]      ff_vec_q, ff_vec_d;
    logic [NUM_ADDERS-1:0] ff_mask_q, ff_mask_d;

    logic [WIDTH:0]        gold;
    logic [WIDTH:0]        ret [NUM_ADDERS];
    logic [NUM_ADDERS-1:0] mism;
    logic                  all_zero;

    assign ret[FF_KSA] = {bus.cout_ksa, bus.sum_ksa};
    assign ret[FF_BKA] = {bus.cout_bka, bus.sum_bka};
    assign ret[FF_SKA] = {bus.cout_ska, bus.sum_ska};

    carry_tree_golden #(.WIDTH(WIDTH)) u_golden (
        .a      (vec_q[WIDTH-1:0]),
        .b      (vec_q[2*WIDTH-1:WIDTH]),
        .cin    (vec_q[2*WIDTH]),
        .result (gold)
    );

    // Per-adder mismatch: sum or carry-out differs from the golden result
    generate
        for (genvar i = 0; i < NUM_ADDERS; i++) begin : g_cmp
            assign mism[i] = (ret[i] != gold);
        end
    endgenerate

    // Next-state, index, counter and first-failure capture logic
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        ff_mask_d  = ff_mask_q;
        for (int i = 0; i < NUM_ADDERS; i++) begin
            err_d[i] = err_q[i];
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    vec_d      = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    ff_mask_d  = '0;
                    for (int i = 0; i < NUM_ADDERS; i++) begin
                        err_d[i] = '0;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // Abort wins over the compare due at this edge
                    state_d = IDLE;
                    vec_d   = '0;
                end else begin
                    for (int i = 0; i < NUM_ADDERS; i++) begin
                        if (mism[i] && (err_q[i] != {ERR_W{1'b1}})) begin
                            err_d[i] = err_q[i] + ERR_W'(1);
                        end
                    end
                    if ((mism != '0) && !ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_q;
                        ff_mask_d  = mism;
                    end
                    if (vec_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = DONE;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
            ff_mask_q  <= '0;
            for (int i = 0; i < NUM_ADDERS; i++) begin
                err_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
            ff_mask_q  <= ff_mask_d;
            for (int i = 0; i < NUM_ADDERS; i++) begin
                err_q[i] <= err_d[i];
            end
        end
    end

    // pass is only meaningful once the sweep has completed
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_ADDERS; i++) begin
            if (err_q[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    assign bus.a        = vec_q[WIDTH-1:0];
    assign bus.b        = vec_q[2*WIDTH-1:WIDTH];
    assign bus.cin      = vec_q[2*WIDTH];
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.pass     = (state_q == DONE) && all_zero;
    assign bus.err_ksa  = err_q[FF_KSA];
    assign bus.err_bka  = err_q[FF_BKA];
    assign bus.err_ska  = err_q[FF_SKA];
    assign bus.ff_valid = ff_valid_q;
    assign bus.ff_vec   = ff_vec_q;
    assign bus.ff_mask  = ff_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_carry_tree_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_tree_sweeper
//  Description : Bench for carry_tree_sweeper with selectable adder faults
//                and a cycle-level behavioural model of the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_tree_sweeper;

    localparam int WIDTH = 4;
    localparam int ERR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    carry_tree_sweeper_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    carry_tree_sweeper #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 0: correct, 1: bka/ska lose full-propagate carry, 2: ksa output stuck 0,
    // 3: pseudo-random corruption of any adder
    int unsigned mode = 0;
    int unsigned seed = 0;

    function automatic logic [4:0] adder_out(input int unsigned adder, input logic [8:0] vec,
                                             input int unsigned md, input int unsigned sd);
        logic [4:0]  t;
        logic [31:0] h;
        t = 5'(vec[3:0]) + 5'(vec[7:4]) + 5'(vec[8]);
        case (md)
            1: if (adder != 0 && (vec[3:0] ^ vec[7:4]) == 4'hF && vec[8]) t[4] = 1'b0;
            2: if (adder == 0) t = 5'd0;
            3: begin
                h = (32'(vec) * 32'd2654435761) ^ (adder * 32'd40503) ^ sd;
                h = h ^ (h >> 13);
                h = h * 32'd2246822519;
                h = h ^ (h >> 16);
                if (h[3:0] == 4'd0) t = t ^ (h[8:4] | 5'd1);
            end
            default: ;
        endcase
        return t;
    endfunction

    logic [8:0] dut_vec;
    assign dut_vec = {bus.cin, bus.b, bus.a};
    assign {bus.cout_ksa, bus.sum_ksa} = adder_out(0, dut_vec, mode, seed);
    assign {bus.cout_bka, bus.sum_bka} = adder_out(1, dut_vec, mode, seed);
    assign {bus.cout_ska, bus.sum_ska} = adder_out(2, dut_vec, mode, seed);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy, m_done, m_ffv;
    int m_idx, m_ffvec, m_ffmask;
    int m_err [3];

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_ffv = 0; m_idx = 0; m_ffvec = 0; m_ffmask = 0;
        for (int k = 0; k < 3; k++) m_err[k] = 0;
    endfunction

    function automatic void model_step(input logic st, input logic ab);
        int gold, mask;
        if (m_busy) begin
            if (ab) begin
                m_busy = 0;
                m_idx  = 0;
            end else begin
                gold = (m_idx % 16) + ((m_idx / 16) % 16) + (m_idx / 256);
                mask = 0;
                for (int k = 0; k < 3; k++) begin
                    if (int'(adder_out(k, 9'(m_idx), mode, seed)) != gold) begin
                        mask = mask | (1 << k);
                        if (m_err[k] < (1 << ERR_W) - 1) m_err[k]++;
                    end
                end
                if (mask != 0 && !m_ffv) begin
                    m_ffv = 1; m_ffvec = m_idx; m_ffmask = mask;
                end
                if (m_idx == 511) begin
                    m_busy = 0; m_done = 1; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end else if (st) begin
            model_reset();
            m_busy = 1;
        end
    endfunction

    // Compare process: advance the model at every edge, check just after
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(bus.start, bus.abort);
            #1;
            check("vec",      dut_vec,      m_busy ? m_idx : 0);
            check("busy",     bus.busy,     m_busy);
            check("done",     bus.done,     m_done);
            check("pass",     bus.pass,     m_done && m_err[0] == 0 && m_err[1] == 0 && m_err[2] == 0);
            check("err_ksa",  bus.err_ksa,  m_err[0]);
            check("err_bka",  bus.err_bka,  m_err[1]);
            check("err_ska",  bus.err_ska,  m_err[2]);
            check("ff_valid", bus.ff_valid, m_ffv);
            check("ff_vec",   bus.ff_vec,   m_ffvec);
            check("ff_mask",  bus.ff_mask,  m_ffmask);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    // Returns at a negedge once busy has dropped (or after an abort edge)
    task automatic run_sweep(input bit do_abort, input int abort_at, input bit glitch,
                             input bit start_w_abort, output int cnt);
        bit finished;
        cnt = 0;
        finished = 0;
        pulse_start();
        for (int i = 0; i < 700; i++) begin
            if (!bus.busy) begin
                finished = 1;
                break;
            end
            cnt++;
            if (do_abort && cnt == abort_at) begin
                bus.abort = 1'b1;
                bus.start = start_w_abort;
                @(negedge clk);
                bus.abort = 1'b0;
                bus.start = 1'b0;
                finished = 1;
                break;
            end
            bus.start = glitch && ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!finished) check("sweep_timeout", 0, 1);
    endtask

    int cnt;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_vec",  dut_vec, 0);
        check("rst_ffv",  bus.ff_valid, 0);

        // Clean adders, with stray start pulses during the sweep
        mode = 0;
        run_sweep(0, 0, 1, 0, cnt);
        check("t1_busy_cycles", cnt, 512);
        check("t1_done", bus.done, 1);
        check("t1_pass", bus.pass, 1);
        check("t1_err_ksa", bus.err_ksa, 0);
        check("t1_ffv", bus.ff_valid, 0);

        // Carry fault on bka/ska, started from DONE
        mode = 1;
        run_sweep(0, 0, 0, 0, cnt);
        check("t2_busy_cycles", cnt, 512);
        check("t2_ff_vec", bus.ff_vec, 'h10F);
        check("t2_ff_mask", bus.ff_mask, 3'b110);
        check("t2_err_ksa", bus.err_ksa, 0);
        check("t2_err_bka", bus.err_bka, 16);
        check("t2_err_ska", bus.err_ska, 16);
        check("t2_pass", bus.pass, 0);

        // ksa output stuck at zero
        mode = 2;
        run_sweep(0, 0, 0, 0, cnt);
        check("t3_ff_vec", bus.ff_vec, 1);
        check("t3_ff_mask", bus.ff_mask, 3'b001);
        check("t3_err_ksa", bus.err_ksa, 511);
        check("t3_pass", bus.pass, 0);

        // Abort in busy cycle 100: vectors 0..98 compared, vector 0 is clean
        run_sweep(1, 100, 0, 0, cnt);
        check("t4_busy", bus.busy, 0);
        check("t4_done", bus.done, 0);
        check("t4_err_ksa", bus.err_ksa, 98);
        check("t4_ff_vec", bus.ff_vec, 1);

        // start together with abort: abort wins
        mode = 0;
        run_sweep(1, 50, 0, 1, cnt);
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);

        // Asynchronous reset mid-sweep
        mode = 2;
        pulse_start();
        repeat (200) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_vec", dut_vec, 0);
        check("t6_err_ksa", bus.err_ksa, 0);
        check("t6_ffv", bus.ff_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        run_sweep(0, 0, 0, 0, cnt);
        check("t7_busy_cycles", cnt, 512);
        check("t7_pass", bus.pass, 1);
        check("t7_err_ksa", bus.err_ksa, 0);

        // Randomised corruption, aborts and stray starts
        for (int it = 0; it < 6; it++) begin
            bit ab;
            int at;
            mode = 3;
            seed = $urandom;
            ab = 1'($urandom_range(0, 1));
            at = int'($urandom_range(1, 520));
            run_sweep(ab, at, 1, 1'($urandom_range(0, 1)), cnt);
            if (!ab || at > 512) check("rand_busy_cycles", cnt, 512);
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
